mod_mux_pipe: RTL and testbench
===============================

// Module: mod_mux_pipe
// PURPOSE
//  - Parametrised, pipelined N-way operand selector for the modular FFT datapath.
//  - Optional conditional modular reduction (x >= M ? x-M : x) on the selected word.
//  - Sits between butterfly outputs and twiddle-multiplier/memory-write ports; replaces ad-hoc 2:1 muxes plus reduction.
//  - Valid tag and stall (enable) travel with data.
// PARAMETERS
//  P_WIDTH  64  data/modulus width in bits
//  N_IN     4   number of selectable operands (>=2)
//  PIPE     2   total latency in cycles (>=2): stage1 select, stage2 reduce, stages 3..PIPE pure delay
//  SEL_W    localparam = clog2(N_IN), min 1
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  en_in      in   1              pipeline advance; 0 = hold every stage
//  valid_in   in   1              input word valid
//  sel_in     in   SEL_W          operand index, 0..N_IN-1
//  data_in    in   N_IN*P_WIDTH   packed operands; operand k = data_in[k*P_WIDTH +: P_WIDTH]
//  mod_in     in   P_WIDTH        modulus M; quasi-static, sampled in stage 2
//  red_in     in   1              1 = apply conditional reduction to this word
//  S_out      out  P_WIDTH        result
//  valid_out  out  1              result valid
//  err_out    out  1              result came from out-of-range sel_in
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage registers, S_out, valid_out and err_out = 0.
//  - en_in=1: every stage loads from its predecessor on the clock edge.
//  - Valid input at cycle t appears at S_out/valid_out at t+PIPE.
//  - en_in=0: all stages, including outputs, hold; inputs are ignored. No bubble is created or lost.
//  - Stage 1:
//    - captures x = operand[sel_in], plus red_in, valid_in and err = (sel_in >= N_IN).
//    - err=1 forces x = 0.
//    - err only matters when N_IN is not a power of 2.
//  - Stage 2:
//    - red=1 and x >= M: y = x - M (P_WIDTH-bit, no carry-out kept).
//    - otherwise: y = x.
//    - Exactly one subtraction; inputs are assumed < 2M. x = M yields 0.
//  - Stages 3..PIPE: registered copies of {y, valid, err}.
//  - Data registers load regardless of valid. S_out with valid_out=0 is don't-care but deterministic.
//  - err_out asserts only together with valid_out.
//  - Reset mid-stream: all in-flight words are discarded. valid_out=0 from the assert edge until new data traverses PIPE stages.
//  - Back-to-back valid inputs are accepted every cycle (throughput 1/clk while en_in=1).
// STRUCTURE
//  - Shared include fftc_mod_defs.vh: default P_WIDTH, clog2 function, modulus constants used by benches.
//  - One sub-module, mod_cond_sub (combinational: x, M, red -> y), instantiated in stage 2 and reusable elsewhere.
//  - Delay stages via a generate loop; PIPE==2 produces no delay registers.
// TESTING
//  1. Reset: assert rst mid-clock with valid_in=1 -> S_out=0, valid_out=0 immediately, held until release.
//  2. Select sweep, N_IN=4, PIPE=2, red=0: operands {11,22,33,44}, sel 0..3 on consecutive cycles -> S_out 11,22,33,44 at t+2.., valid_out=1 each.
//  3. Reduction, M=17, red=1: x=16 -> 16; x=17 -> 0; x=33 -> 16. Same words with red=0 -> unchanged.
//  4. Stall: stream of 4 valid words, en_in=0 for 3 cycles mid-stream -> outputs frozen, no duplicates or drops, order preserved.
//  5. N_IN=3, sel_in=3, valid -> S_out=0, err_out=1, valid_out=1. Legal sel -> err_out=0.
//  6. PIPE=4, P_WIDTH=64, M=0xFFFF_FFFF_0000_0001, x=M+5, red=1 -> S_out=5 exactly 4 cycles later.

Source files
------------

// File: rtl/mod_mux_pipe_pkg.sv
// Shared constants and helpers for the modular FFT operand-select/reduce pipeline.
// Benches use the modulus constants from here.
package mod_mux_pipe_pkg;

    localparam int          DEF_P_WIDTH    = 64;
    localparam logic [63:0] MOD_GOLDILOCKS = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] MOD_SMALL_17   = 64'd17;

    // Ceiling log2, but never below 1 so that a select field always has at least one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional modular reduction: y = (red && x >= m) ? x - m : x.
// Inputs are assumed to be below 2m, so a single subtraction is enough.
module mod_cond_sub
    import mod_mux_pipe_pkg::*;
#(
    parameter int P_WIDTH = DEF_P_WIDTH
) (
    input  logic [P_WIDTH-1:0] x,
    input  logic [P_WIDTH-1:0] m,
    input  logic               red,
    output logic [P_WIDTH-1:0] y
);

    always_comb begin
        y = x;
        if (red && (x >= m)) begin
            y = x - m;
        end
    end

endmodule

// File: rtl/mod_mux_pipe.sv
// Pipelined N-way operand selector with optional conditional modular reduction.
// Stage 1 selects, stage 2 reduces, remaining stages are pure delay; en_in stalls everything.
module mod_mux_pipe
    import mod_mux_pipe_pkg::*;
#(
    parameter  int P_WIDTH = DEF_P_WIDTH,
    parameter  int N_IN    = 4,
    parameter  int PIPE    = 2,
    localparam int SEL_W   = clog2_min1(N_IN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_in,
    input  logic                      valid_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [N_IN*P_WIDTH-1:0]   data_in,
    input  logic [P_WIDTH-1:0]        mod_in,
    input  logic                      red_in,
    output logic [P_WIDTH-1:0]        S_out,
    output logic                      valid_out,
    output logic                      err_out
);

    typedef struct packed {
        logic [P_WIDTH-1:0] data;
        logic               red;
        logic               valid;
        logic               err;
    } sel_stage_t;

    typedef struct packed {
        logic [P_WIDTH-1:0] data;
        logic               valid;
        logic               err;
    } stage_t;

    genvar gi;

    logic [P_WIDTH-1:0] operand [N_IN];
    logic [P_WIDTH-1:0] sel_word;
    logic               sel_err;
    logic [P_WIDTH-1:0] red_word;

    sel_stage_t s1_reg;
    stage_t     s2_reg;
    stage_t     out_stage;

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_operand
            assign operand[gi] = data_in[gi*P_WIDTH +: P_WIDTH];
        end
    endgenerate

    // Out-of-range selects match no operand, so they fall through to zero.
    always_comb begin
        sel_word = '0;
        sel_err  = (32'(sel_in) >= N_IN);
        for (int k = 0; k < N_IN; k++) begin
            if (32'(sel_in) == k) begin
                sel_word = operand[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= '0;
        end else if (en_in) begin
            s1_reg.data  <= sel_err ? '0 : sel_word;
            s1_reg.red   <= red_in;
            s1_reg.valid <= valid_in;
            s1_reg.err   <= sel_err & valid_in;
        end
    end

    mod_cond_sub #(
        .P_WIDTH (P_WIDTH)
    ) u_cond_sub (
        .x   (s1_reg.data),
        .m   (mod_in),
        .red (s1_reg.red),
        .y   (red_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_reg <= '0;
        end else if (en_in) begin
            s2_reg.data  <= red_word;
            s2_reg.valid <= s1_reg.valid;
            s2_reg.err   <= s1_reg.err;
        end
    end

    generate
        for (gi = 0; gi < PIPE - 2; gi++) begin : g_dly
            stage_t d_in;
            stage_t q_reg;
            if (gi == 0) begin : g_head
                assign d_in = s2_reg;
            end else begin : g_tail
                assign d_in = g_dly[gi-1].q_reg;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (en_in) begin
                    q_reg <= d_in;
                end
            end
        end

        if (PIPE == 2) begin : g_out_direct
            assign out_stage = s2_reg;
        end else begin : g_out_delayed
            assign out_stage = g_dly[PIPE-3].q_reg;
        end
    endgenerate

    assign S_out     = out_stage.data;
    assign valid_out = out_stage.valid;
    assign err_out   = out_stage.err;

endmodule

// File: tb/tb_mod_mux_pipe.sv
// Scoreboard bench: three instances (4-way/2-stage, 3-way/2-stage, 4-way/4-stage) share stimulus;
// the driver queues hand-computed results and a negedge monitor checks data, err, order and latency.
module tb_mod_mux_pipe;
    import mod_mux_pipe_pkg::*;

    localparam int          W  = 64;
    localparam logic [63:0] GM = MOD_GOLDILOCKS;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_in;
    logic          valid_in;
    logic [1:0]    sel_in;
    logic          red_in;
    logic [W-1:0]  mod_in;
    logic [W-1:0]  op0, op1, op2, op3;
    logic [4*W-1:0] data4;
    logic [3*W-1:0] data3;

    logic [W-1:0]  s_o [3];
    logic          v_o [3];
    logic          e_o [3];

    exp_t          q_exp [3][$];
    logic [63:0]   prev_s [3];
    logic          prev_v [3];
    int            pipe_of [3] = '{2, 2, 4};

    int            n_checks = 0;
    int            n_fail   = 0;
    int            adv      = 0;
    logic          hold_chk = 1'b0;

    assign data4 = {op3, op2, op1, op0};
    assign data3 = {op2, op1, op0};

    always #5 clk = ~clk;

    mod_mux_pipe #(.P_WIDTH(W), .N_IN(4), .PIPE(2)) dut_a (
        .clk(clk), .rst(rst), .en_in(en_in), .valid_in(valid_in), .sel_in(sel_in),
        .data_in(data4), .mod_in(mod_in), .red_in(red_in),
        .S_out(s_o[0]), .valid_out(v_o[0]), .err_out(e_o[0])
    );

    mod_mux_pipe #(.P_WIDTH(W), .N_IN(3), .PIPE(2)) dut_b (
        .clk(clk), .rst(rst), .en_in(en_in), .valid_in(valid_in), .sel_in(sel_in),
        .data_in(data3), .mod_in(mod_in), .red_in(red_in),
        .S_out(s_o[1]), .valid_out(v_o[1]), .err_out(e_o[1])
    );

    mod_mux_pipe #(.P_WIDTH(W), .N_IN(4), .PIPE(4)) dut_c (
        .clk(clk), .rst(rst), .en_in(en_in), .valid_in(valid_in), .sel_in(sel_in),
        .data_in(data4), .mod_in(mod_in), .red_in(red_in),
        .S_out(s_o[2]), .valid_out(v_o[2]), .err_out(e_o[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enabled clock edges outside reset; a word issued at count A is due at A+PIPE.
    always @(posedge clk) begin
        hold_chk <= !rst && !en_in;
        if (!rst && en_in) begin
            adv <= adv + 1;
        end
    end

    task automatic monitor_one(input int id);
        exp_t x;
        if (!rst) begin
            check($sformatf("err_without_valid[%0d]", id), 64'(e_o[id] && !v_o[id]), 64'd0);
            if (hold_chk) begin
                check($sformatf("hold_data[%0d]", id), s_o[id], prev_s[id]);
                check($sformatf("hold_valid[%0d]", id), 64'(v_o[id]), 64'(prev_v[id]));
            end else if (v_o[id]) begin
                if (q_exp[id].size() == 0) begin
                    check($sformatf("spurious_valid[%0d]", id), 64'd1, 64'd0);
                end else begin
                    x = q_exp[id].pop_front();
                    check($sformatf("data[%0d]", id), s_o[id], x.data);
                    check($sformatf("err[%0d]", id), 64'(e_o[id]), 64'(x.err));
                    check($sformatf("latency[%0d]", id), 64'(adv), 64'(x.due));
                    $display("dut%0d out data=%h err=%0b", id, s_o[id], e_o[id]);
                end
            end
        end
        prev_s[id] = s_o[id];
        prev_v[id] = v_o[id];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            monitor_one(i);
        end
    end

    task automatic issue(input logic [1:0] sel, input logic red,
                         input logic [63:0] e4, input logic [63:0] e3, input logic err3);
        sel_in   = sel;
        red_in   = red;
        valid_in = 1'b1;
        en_in    = 1'b1;
        q_exp[0].push_back('{data: e4, err: 1'b0, due: adv + pipe_of[0]});
        q_exp[1].push_back('{data: e3, err: err3, due: adv + pipe_of[1]});
        q_exp[2].push_back('{data: e4, err: 1'b0, due: adv + pipe_of[2]});
        $display("issue sel=%0d red=%0b exp4=%h exp3=%h err3=%0b", sel, red, e4, e3, err3);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        en_in    = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Stalled cycles present a valid-looking word that must be ignored.
    task automatic stall(input int n);
        en_in    = 1'b0;
        valid_in = 1'b1;
        sel_in   = 2'd3;
        repeat (n) @(negedge clk);
        en_in    = 1'b1;
        valid_in = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_S_out[%0d]", tag, i), s_o[i], 64'd0);
            check($sformatf("%s_valid_out[%0d]", tag, i), 64'(v_o[i]), 64'd0);
            check($sformatf("%s_err_out[%0d]", tag, i), 64'(e_o[i]), 64'd0);
        end
    endtask

    task automatic set_ops(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d);
        op0 = a; op1 = b; op2 = c; op3 = d;
    endtask

    initial begin
        rst = 1'b1; en_in = 1'b1; valid_in = 1'b0; sel_in = 2'd0; red_in = 1'b0;
        mod_in = MOD_SMALL_17;
        set_ops(64'd0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        idle(2);

        // Select sweep, no reduction
        set_ops(64'd11, 64'd22, 64'd33, 64'd44);
        issue(2'd0, 1'b0, 64'd11, 64'd11, 1'b0);
        issue(2'd1, 1'b0, 64'd22, 64'd22, 1'b0);
        issue(2'd2, 1'b0, 64'd33, 64'd33, 1'b0);
        issue(2'd3, 1'b0, 64'd44, 64'd0,  1'b1);
        idle(3);

        // Reduction by 17, then the same words unreduced
        set_ops(64'd16, 64'd17, 64'd33, 64'd44);
        issue(2'd0, 1'b1, 64'd16, 64'd16, 1'b0);
        issue(2'd1, 1'b1, 64'd0,  64'd0,  1'b0);
        issue(2'd2, 1'b1, 64'd16, 64'd16, 1'b0);
        issue(2'd0, 1'b0, 64'd16, 64'd16, 1'b0);
        issue(2'd1, 1'b0, 64'd17, 64'd17, 1'b0);
        issue(2'd2, 1'b0, 64'd33, 64'd33, 1'b0);
        issue(2'd3, 1'b1, 64'd27, 64'd0,  1'b1);
        idle(3);

        // Stall mid-stream
        set_ops(64'd11, 64'd22, 64'd33, 64'd44);
        issue(2'd0, 1'b0, 64'd11, 64'd11, 1'b0);
        issue(2'd1, 1'b0, 64'd22, 64'd22, 1'b0);
        stall(3);
        issue(2'd2, 1'b0, 64'd33, 64'd33, 1'b0);
        issue(2'd3, 1'b0, 64'd44, 64'd0,  1'b1);
        idle(6);

        // 64-bit Goldilocks modulus; change M only while the pipe is empty
        mod_in = GM;
        idle(3);
        set_ops(GM + 64'd5, GM - 64'd1, GM, 64'd5);
        issue(2'd0, 1'b1, 64'd5,       64'd5,       1'b0);
        issue(2'd1, 1'b1, GM - 64'd1,  GM - 64'd1,  1'b0);
        issue(2'd2, 1'b1, 64'd0,       64'd0,       1'b0);
        issue(2'd3, 1'b1, 64'd5,       64'd0,       1'b1);
        idle(6);

        // Asynchronous reset mid-clock with words in flight
        mod_in = MOD_SMALL_17;
        idle(3);
        set_ops(64'd11, 64'd22, 64'd33, 64'd44);
        issue(2'd0, 1'b0, 64'd11, 64'd11, 1'b0);
        issue(2'd1, 1'b0, 64'd22, 64'd22, 1'b0);
        valid_in = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            q_exp[i].delete();
        end
        check_reset_state("async_reset");
        repeat (2) @(negedge clk);
        check_reset_state("reset_held");
        valid_in = 1'b0;
        rst = 1'b0;
        idle(1);
        issue(2'd2, 1'b0, 64'd33, 64'd33, 1'b0);
        idle(8);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("drained[%0d]", i), 64'(q_exp[i].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
